// File: rtl/data_cache_l1_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_cache_l1_wb : write-back / write-allocate L1 data cache, 32 B lines,|
// |                    1- or 2-way with LRU, full flush support              |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module data_cache_l1_wb #(
  parameter int NUM_SETS = 64,
  parameter int WAYS     = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       wdata,
  input  logic [1:0]        wsize,
  output logic [31:0]       rdata,
  output logic              valid_out,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              blk_read,
  input  logic [255:0]      blk_rdata,
  input  logic              blk_rvalid,
  output logic              blk_write,
  output logic [255:0]      blk_wdata,
  input  logic              blk_wvalid
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 5 - IDX_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FSCAN = 3'd3;
  localparam logic [2:0] S_FWB   = 3'd4;
  localparam logic [2:0] S_FDONE = 3'd5;

  logic [2:0]          r_state;
  logic [NUM_SETS-1:0] r_valid [WAYS];
  logic [NUM_SETS-1:0] r_dirty [WAYS];
  logic [NUM_SETS-1:0] r_lru;
  logic [TAG_W-1:0]    r_tag   [WAYS][NUM_SETS];
  logic [255:0]        r_data  [WAYS][NUM_SETS];
  logic                r_vway;
  logic [IDX_W-1:0]    r_fset;
  logic                r_fway;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [2:0]       w_word;
  logic             w_access, w_hit, w_hway, w_vway, w_serve;
  logic             w_wr_hit, w_fill_done, w_fadv, w_flast;
  logic [2:0]       w_nbytes;
  logic [5:0]       w_lsh;
  logic [4:0]       w_rsh;
  logic [31:0]      w_mask, w_wal, w_word_old, w_word_new;

  assign w_idx    = addr[5 +: IDX_W];
  assign w_tag    = addr[ADDR_W-1 -: TAG_W];
  assign w_word   = addr[4:2];
  assign w_access = read | write;

  always_comb begin
    w_hit  = 1'b0;
    w_hway = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = 1'(w);
      end
    end
    // Lowest-numbered invalid way wins; otherwise evict the LRU way.
    w_vway = (WAYS > 1) ? r_lru[w_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_vway = 1'(w);
    end
  end

  assign w_serve     = (r_state == S_IDLE) && w_access && w_hit;
  assign w_wr_hit    = w_serve && write;
  assign w_fill_done = (r_state == S_FILL) && blk_rvalid;
  assign valid_out   = w_serve;
  assign w_word_old  = r_data[w_hway][w_idx][{w_word, 5'b00000} +: 32];
  assign rdata       = w_serve ? w_word_old : 32'h0;

  // Big-endian placement: left-justify the N-byte value, then slide to the byte offset;
  // anything pushed past the word's low end falls off.
  assign w_nbytes   = (wsize == 2'd0) ? 3'd4 : {1'b0, wsize};
  assign w_lsh      = {3'(3'd4 - w_nbytes), 3'b000};
  assign w_rsh      = {addr[1:0], 3'b000};
  assign w_mask     = (32'hFFFF_FFFF << w_lsh) >> w_rsh;
  assign w_wal      = (wdata << w_lsh) >> w_rsh;
  assign w_word_new = (w_word_old & ~w_mask) | (w_wal & w_mask);

  assign w_flast = (r_fset == IDX_W'(NUM_SETS - 1)) && (r_fway == 1'(WAYS - 1));
  assign w_fadv  = ((r_state == S_FSCAN) && !r_dirty[r_fway][r_fset]) ||
                   ((r_state == S_FWB) && blk_wvalid);

  always_comb begin
    blk_read    = 1'b0;
    blk_write   = 1'b0;
    blk_wdata   = '0;
    mem_address = '0;
    flush_done  = 1'b0;
    case (r_state)
      S_WB: begin
        blk_write   = 1'b1;
        mem_address = {r_tag[r_vway][w_idx], w_idx, 5'b00000};
        blk_wdata   = r_data[r_vway][w_idx];
      end
      S_FILL: begin
        blk_read    = 1'b1;
        mem_address = {w_tag, w_idx, 5'b00000};
      end
      S_FWB: begin
        blk_write   = 1'b1;
        mem_address = {r_tag[r_fway][r_fset], r_fset, 5'b00000};
        blk_wdata   = r_data[r_fway][r_fset];
      end
      S_FDONE: flush_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_vway  <= 1'b0;
      r_fset  <= '0;
      r_fway  <= 1'b0;
      r_lru   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_hit) begin
              r_lru[w_idx] <= ~w_hway;
              if (write) r_dirty[w_hway][w_idx] <= 1'b1;
            end else begin
              r_vway  <= w_vway;
              r_state <= r_dirty[w_vway][w_idx] ? S_WB : S_FILL;
            end
          end else if (flush_req) begin
            r_fset  <= '0;
            r_fway  <= 1'b0;
            r_state <= S_FSCAN;
          end
        end
        S_WB:    if (blk_wvalid) r_state <= S_FILL;
        S_FILL: begin
          if (blk_rvalid) begin
            r_valid[r_vway][w_idx] <= 1'b1;
            r_dirty[r_vway][w_idx] <= 1'b0;
            r_lru[w_idx]           <= ~r_vway;
            r_state                <= S_IDLE;
          end
        end
        S_FSCAN: if (r_dirty[r_fway][r_fset]) r_state <= S_FWB;
        S_FWB:   ;
        S_FDONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_fadv) begin
        r_valid[r_fway][r_fset] <= 1'b0;
        r_dirty[r_fway][r_fset] <= 1'b0;
        if (w_flast) begin
          r_state <= S_FDONE;
        end else if (r_fway == 1'(WAYS - 1)) begin
          r_fway  <= 1'b0;
          r_fset  <= r_fset + 1'b1;
          r_state <= S_FSCAN;
        end else begin
          r_fway  <= 1'b1;
          r_state <= S_FSCAN;
        end
      end
    end
  end

  // Line payload and tags need no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_hway][w_idx][{w_word, 5'b00000} +: 32] <= w_word_new;
    if (w_fill_done) begin
      r_data[r_vway][w_idx] <= blk_rdata;
      r_tag[r_vway][w_idx]  <= w_tag;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_data_cache_l1_wb.sv
`default_nettype none
// tb_data_cache_l1_wb: directed and randomized checks of data_cache_l1_wb against a
// flat byte-memory view plus a per-set recency list of resident lines.
module tb_data_cache_l1_wb;
  localparam int NSETS = 64;
  localparam int NWAYS = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  addr = '0;
  logic         read = 1'b0, write = 1'b0;
  logic [31:0]  wdata = '0;
  logic [1:0]   wsize = '0;
  logic [31:0]  rdata;
  logic         valid_out;
  logic         flush_req = 1'b0;
  logic         flush_done;
  logic [31:0]  mem_address;
  logic         blk_read;
  logic [255:0] blk_rdata;
  logic         blk_rvalid;
  logic         blk_write;
  logic [255:0] blk_wdata;
  logic         blk_wvalid;

  always #5 CLK = ~CLK;

  data_cache_l1_wb #(.NUM_SETS(NSETS), .WAYS(NWAYS), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .addr(addr), .read(read), .write(write),
    .wdata(wdata), .wsize(wsize), .rdata(rdata), .valid_out(valid_out),
    .flush_req(flush_req), .flush_done(flush_done), .mem_address(mem_address),
    .blk_read(blk_read), .blk_rdata(blk_rdata), .blk_rvalid(blk_rvalid),
    .blk_write(blk_write), .blk_wdata(blk_wdata), .blk_wvalid(blk_wvalid)
  );

  int errors = 0;
  int checks = 0;

  logic [255:0] bmem [int unsigned];   // backing memory as the DUT sees it
  logic [255:0] gmem [int unsigned];   // architectural memory as the CPU sees it
  int unsigned  mq [NSETS][$];         // resident lines per set, most recent first
  bit           mdirty [int unsigned];
  bit           fl_exp [int unsigned];
  logic [32:0]  ev_log [$];            // {is_write, address} of each block request

  bit          cur_active = 0, cur_first = 0, cur_done = 0;
  bit          exp_wb_valid = 0;
  int unsigned exp_wb_line = 0;
  bit          done_hit = 0;
  logic [31:0] done_rdata = '0;
  bit          flushing = 0, fl_done = 0;
  int          fl_writes = 0, fl_cycles = 0, wb_cycles = 0;
  bit          rd_block = 0;
  int          wr_wait = 0, rd_wait = 0;

  function automatic logic [255:0] pat(input int unsigned l);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = (l * 32'h9E37_79B1) ^ (32'h0101_0101 * (i + 1));
    return v;
  endfunction

  function automatic logic [255:0] gline(input int unsigned l);
    return gmem.exists(l) ? gmem[l] : pat(l);
  endfunction

  function automatic logic [255:0] bline(input int unsigned l);
    return bmem.exists(l) ? bmem[l] : pat(l);
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Store of n bytes at byte offset b: offset b+k receives value byte n-1-k; past offset 3 is lost.
  task automatic gstore(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] ws);
    int n, b, wi;
    int unsigned l;
    logic [255:0] ln;
    n = (ws == 2'd0) ? 4 : int'(ws);
    b = int'(a[1:0]);
    wi = int'(a[4:2]);
    l = a >> 5;
    ln = gline(l);
    for (int k = 0; k < n; k++)
      if (b + k < 4) ln[32*wi + 31 - 8*(b+k) -: 8] = wd[8*(n-1-k) +: 8];
    gmem[l] = ln;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NSETS; s++) mq[s].delete();
    mdirty.delete();
    exp_wb_valid = 0;
  endtask

  // Monitor and memory responder: checks every cycle, then answers block requests.
  initial begin : mon
    bit lwv, lrv, new_wb, new_rd, hit, prev_bw, prev_br;
    logic [31:0] prev_addr;
    logic [255:0] prev_wdata, lt;
    int unsigned ln, st, vic;
    prev_bw = 0; prev_br = 0; prev_addr = '0; prev_wdata = '0;
    blk_rvalid = 0; blk_wvalid = 0; blk_rdata = '0;
    forever begin
      @(negedge CLK);
      lwv = blk_wvalid; lrv = blk_rvalid;
      blk_wvalid = 0; blk_rvalid = 0;
      if (RESET) begin
        prev_bw = 0; prev_br = 0;
        continue;
      end
      new_wb = blk_write && (!prev_bw || lwv);
      new_rd = blk_read && (!prev_br || lrv);
      chk(!(blk_read && blk_write), "blk_exclusive", {blk_read, blk_write}, 0);
      chk(!(valid_out && (blk_read || blk_write || flush_done)), "valid_only_idle", valid_out, 0);
      if (blk_write && prev_bw && !lwv)
        chk(mem_address == prev_addr && blk_wdata == prev_wdata, "wb_stable", mem_address, prev_addr);
      if (!flushing) chk(!flush_done, "flush_done_spurious", flush_done, 0);
      if (!cur_active) chk(!valid_out, "valid_without_req", valid_out, 0);
      if (new_wb) ev_log.push_back({1'b1, mem_address});
      if (new_rd) ev_log.push_back({1'b0, mem_address});
      if (blk_write) wb_cycles++;

      if (flushing) begin
        fl_cycles++;
        chk(!blk_read, "flush_no_read", blk_read, 0);
        if (new_wb) begin
          ln = mem_address >> 5;
          lt = gline(ln);
          chk(fl_exp.exists(ln), "flush_wb_addr", mem_address, 0);
          chk(blk_wdata == lt, "flush_wb_data", blk_wdata, lt);
          fl_exp.delete(ln);
          fl_writes++;
        end
        if (flush_done) begin
          chk(fl_exp.size() == 0, "flush_all_dirty_written", fl_exp.size(), 0);
          model_clear();
          fl_done = 1;
        end
      end else if (cur_active) begin
        ln = addr >> 5;
        st = ln % NSETS;
        if (cur_first) begin
          hit = 0;
          for (int i = 0; i < mq[st].size(); i++)
            if (mq[st][i] == ln) begin hit = 1; mq[st].delete(i); break; end
          exp_wb_valid = 0;
          if (!hit && mq[st].size() == NWAYS) begin
            vic = mq[st].pop_back();
            if (mdirty.exists(vic)) begin
              exp_wb_valid = 1; exp_wb_line = vic; mdirty.delete(vic);
            end
          end
          mq[st].push_front(ln);
          done_hit = hit;
          chk(valid_out == hit, "hit_prediction", valid_out, hit);
          cur_first = 0;
        end
        if (new_wb) begin
          lt = gline(exp_wb_line);
          chk(exp_wb_valid && mem_address == (exp_wb_line << 5), "wb_addr", mem_address, exp_wb_line << 5);
          chk(blk_wdata == lt, "wb_data", blk_wdata, lt);
          exp_wb_valid = 0;
        end
        if (new_rd) chk(!exp_wb_valid && mem_address == (ln << 5), "rd_addr", mem_address, ln << 5);
        if (valid_out) begin
          lt = gline(ln);
          chk(rdata == lt[{addr[4:2], 5'b00000} +: 32], "rdata", rdata, lt[{addr[4:2], 5'b00000} +: 32]);
          chk(!exp_wb_valid, "wb_missing", exp_wb_valid, 0);
          done_rdata = rdata;
          if (write) begin gstore(addr, wdata, wsize); mdirty[ln] = 1; end
          cur_done = 1;
        end
      end
      prev_bw = blk_write; prev_br = blk_read; prev_addr = mem_address; prev_wdata = blk_wdata;

      if (blk_write) begin
        if (wr_wait <= 0) begin
          bmem[mem_address >> 5] = blk_wdata;
          blk_wvalid = 1;
          wr_wait = $urandom_range(0, 3);
        end else wr_wait--;
      end
      if (blk_read && !rd_block) begin
        if (rd_wait <= 0) begin
          blk_rdata = bline(mem_address >> 5);
          blk_rvalid = 1;
          rd_wait = $urandom_range(0, 3);
        end else rd_wait--;
      end
    end
  end

  task automatic do_reset();
    RESET = 1; read = 0; write = 0; flush_req = 0; cur_active = 0;
    @(negedge CLK);
    chk(!valid_out && rdata == 0 && !blk_read && !blk_write && !flush_done, "reset_outputs",
        {valid_out, rdata, blk_read, blk_write, flush_done}, 0);
    model_clear();
    gmem = bmem;
    @(posedge CLK);
    #1 RESET = 0;
  endtask

  task automatic access(input logic [31:0] a, input bit w, input logic [31:0] wd,
                        input logic [1:0] ws, input bit both);
    addr = a; write = w; read = !w || both; wdata = wd; wsize = ws;
    cur_done = 0; cur_first = 1; cur_active = 1;
    for (int n = 0; n < 500 && !cur_done; n++) @(posedge CLK);
    chk(cur_done, "access_timeout", cur_done, 1);
    #1 read = 0; write = 0; cur_active = 0;
  endtask

  task automatic do_flush(output int nwr, output int ncyc);
    fl_exp = mdirty;
    fl_writes = 0; fl_cycles = 0; fl_done = 0;
    flushing = 1; flush_req = 1;
    for (int n = 0; n < 3000 && !fl_done; n++) @(posedge CLK);
    chk(fl_done, "flush_timeout", fl_done, 1);
    #1 flush_req = 0; flushing = 0;
    nwr = fl_writes; ncyc = fl_cycles;
  endtask

  initial begin : main
    int nw, nc, n;
    bit seen;
    logic [255:0] ln;
    int unsigned line;
    int op;

    @(posedge CLK); #1;
    do_reset();

    // Cold miss then hit on 0x100, then a one-byte big-endian store.
    ln = pat(8); ln[31:0] = 32'hDEAD_BEEF; bmem[8] = ln; gmem[8] = ln;
    access(32'h100, 0, 0, 0, 0);
    chk(done_hit == 0, "t1_first_miss", done_hit, 0);
    chk(ev_log.size() > 0 && ev_log[ev_log.size()-1] == {1'b0, 32'h100}, "t1_blk_read_addr",
        ev_log[ev_log.size()-1], {1'b0, 32'h100});
    chk(done_rdata == 32'hDEAD_BEEF, "t1_rdata", done_rdata, 32'hDEAD_BEEF);
    n = ev_log.size();
    access(32'h100, 0, 0, 0, 0);
    chk(done_hit == 1 && ev_log.size() == n, "t1_rehit", done_hit, 1);
    access(32'h101, 1, 32'h0000_00AB, 2'd1, 0);
    access(32'h100, 0, 0, 0, 0);
    chk(done_rdata == 32'hDEAB_BEEF, "t2_byte_store", done_rdata, 32'hDEAB_BEEF);

    // Dirty LRU victim is written back before the refill.
    do_reset();
    access(32'h0, 0, 0, 0, 0);
    access(32'h800, 0, 0, 0, 0);
    access(32'h0, 1, 32'h1234_5678, 2'd0, 0);
    access(32'h800, 0, 0, 0, 0);
    n = ev_log.size();
    access(32'h1000, 0, 0, 0, 0);
    chk(ev_log.size() == n + 2 && ev_log[n] == {1'b1, 32'h0}, "t3_wb_first", ev_log[n], {1'b1, 32'h0});
    chk(ev_log.size() == n + 2 && ev_log[n+1] == {1'b0, 32'h1000}, "t3_read_second",
        ev_log[n+1], {1'b0, 32'h1000});

    // Flush with three dirty lines.
    do_reset();
    access(32'h20, 1, 32'h1111_1111, 2'd0, 0);
    access(32'h44, 1, 32'h2222, 2'd2, 0);
    access(32'h63, 1, 32'h33, 2'd1, 0);
    do_flush(nw, nc);
    chk(nw == 3, "t4_flush_writes", nw, 3);
    chk(nc >= NSETS * NWAYS, "t4_flush_visits", nc, NSETS * NWAYS);
    access(32'h20, 0, 0, 0, 0);
    chk(done_hit == 0, "t4_miss_after_flush", done_hit, 0);

    // Memory stalls the write-back for ten cycles.
    do_reset();
    access(32'h0, 1, 32'hCAFE_F00D, 2'd0, 0);
    access(32'h800, 0, 0, 0, 0);
    wr_wait = 10; wb_cycles = 0;
    access(32'h1000, 0, 0, 0, 0);
    chk(wb_cycles == 11, "t5_wb_hold_cycles", wb_cycles, 11);

    // Reset in the middle of a refill.
    do_reset();
    rd_block = 1;
    addr = 32'h200; read = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = blk_read;
    end
    chk(seen, "t6_fill_started", seen, 1);
    #2 RESET = 1;
    #1 chk(!blk_read, "t6_reset_drops_read", blk_read, 0);
    read = 0;
    rd_block = 0;
    do_reset();
    access(32'h200, 0, 0, 0, 0);
    chk(done_hit == 0, "t6_miss_after_reset", done_hit, 0);

    // Randomized traffic over 16 lines mapped onto 4 sets.
    for (int it = 0; it < 400; it++) begin
      line = ($urandom_range(0, 3) << 6) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 59) == 0) do_flush(nw, nc);
      access((line << 5) | $urandom_range(0, 31), op < 5, $urandom, 2'($urandom_range(0, 3)), op == 0);
    end
    do_flush(nw, nc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
